// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
package bcd_pkg;
  localparam int IN_W       = 14;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W      = 4;
  localparam logic [IN_W-1:0] MAX_VAL = 14'd9999;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;
endpackage

// File: rtl/bin_to_bcd_if.sv
// Start/done handshake plus digit outputs between a numeric source and the converter.
interface bin_to_bcd_if;
  logic                         start;
  logic [bcd_pkg::IN_W-1:0]     number;
  logic                         busy;
  logic                         done;
  logic                         overflow;
  logic [bcd_pkg::DIGIT_W-1:0]  thousands;
  logic [bcd_pkg::DIGIT_W-1:0]  hundreds;
  logic [bcd_pkg::DIGIT_W-1:0]  tens;
  logic [bcd_pkg::DIGIT_W-1:0]  ones;

  modport master (
    output start, number,
    input  busy, done, overflow, thousands, hundreds, tens, ones
  );

  modport slave (
    input  start, number,
    output busy, done, overflow, thousands, hundreds, tens, ones
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more, so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);
  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
endmodule

// File: rtl/bin_to_bcd.sv
// Iterative 14-bit binary to 4-digit BCD converter (shift-and-add-3).
// One shift per cycle: digits update with a done pulse 14 edges after start.
module bin_to_bcd
  import bcd_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  bin_to_bcd_if.slave  bus
);
  state_e               state_q, state_d;
  logic [IN_W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [BCD_W-1:0]     digits_q, digits_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic [BCD_W-1:0]     adj;
  logic [BCD_W-1:0]     shift_scratch;
  logic [IN_W-1:0]      shift_bin;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Scratch and binary shift together as one register; the binary MSB feeds the BCD LSB.
  assign {shift_scratch, shift_bin} = {adj, bin_q} << 1;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    digits_d  = digits_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.number > MAX_VAL) begin
            bin_d = MAX_VAL;
            ovf_d = 1'b1;
          end else begin
            bin_d = bus.number;
            ovf_d = 1'b0;
          end
          scratch_d = '0;
          cnt_d     = CNT_W'(IN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shift_scratch;
        bin_d     = shift_bin;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          digits_d = shift_scratch;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      digits_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.thousands = digits_q[3*DIGIT_W +: DIGIT_W];
  assign bus.hundreds  = digits_q[2*DIGIT_W +: DIGIT_W];
  assign bus.tens      = digits_q[1*DIGIT_W +: DIGIT_W];
  assign bus.ones      = digits_q[0*DIGIT_W +: DIGIT_W];
endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: expected {overflow, digits} queued at start, checked at done.
module tb_bin_to_bcd;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_bcd_if bus ();

  bin_to_bcd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [16:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] model(int n);
    int s;
    logic ov;
    ov = (n > 9999);
    s  = ov ? 9999 : n;
    return {ov, 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.ones};
  endfunction

  task automatic issue(int n);
    bus.number = 14'(n);
    bus.start  = 1'b1;
    sb.push_back(model(n));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.number = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got busy,done=%b%b want 00", bus.busy, bus.done);
    end
    checks++;
    if (observed() !== 17'd0) begin
      failures++;
      $display("FAIL reset_digits got %h want 0", observed());
    end
  endtask

  task automatic test_units_tens();
    bit ok;
    logic [16:0] exp;
    for (int v = 5; v <= 14; v++) begin
      issue(v);
      wait_done(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL units_timeout value=%0d got no done want done", v);
        sb.delete();
      end else begin
        exp = sb.pop_front();
        if (observed() !== exp) begin
          failures++;
          $display("FAIL units value=%0d got %h want %h", v, observed(), exp);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    int lo[4] = '{95, 995, 9995, 0};
    int hi[4] = '{104, 1004, 9999, 0};
    bit ok;
    logic [16:0] exp;
    for (int r = 0; r < 4; r++) begin
      for (int v = lo[r]; v <= hi[r]; v++) begin
        issue(v);
        wait_done(ok);
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL boundary_timeout value=%0d got no done want done", v);
          sb.delete();
        end else begin
          exp = sb.pop_front();
          if (observed() !== exp) begin
            failures++;
            $display("FAIL boundary value=%0d got %h want %h", v, observed(), exp);
          end
        end
      end
    end
  endtask

  task automatic test_timing();
    logic [16:0] prev;
    logic [16:0] exp;
    int errs = 0;
    repeat (3) @(negedge clk);
    prev = observed();
    issue(1234);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || observed() !== prev) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL busy_window got %0d bad cycles want 0", errs);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      failures++;
      $display("FAIL done_edge got done,busy=%b%b want 10", bus.done, bus.busy);
    end
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL timing_digits got %h want %h", observed(), exp);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_mid_start();
    bit ok;
    bit extra = 1'b0;
    logic [16:0] exp;
    issue(4321);
    repeat (5) @(negedge clk);
    bus.number = 14'd555;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_start_timeout got no done want done");
      sb.delete();
    end else begin
      exp = sb.pop_front();
      if (observed() !== exp) begin
        failures++;
        $display("FAIL mid_start_digits got %h want %h", observed(), exp);
      end
    end
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL mid_start_ignored got extra activity want none");
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int t1, t2;
    logic [16:0] exp;
    issue(111);
    wait_done(ok1);
    t1 = cyc;
    checks++;
    if (!ok1) begin
      failures++;
      $display("FAIL b2b_first_timeout got no done want done");
      sb.delete();
    end else begin
      exp = sb.pop_front();
      if (observed() !== exp) begin
        failures++;
        $display("FAIL b2b_first got %h want %h", observed(), exp);
      end
    end
    issue(2222);
    wait_done(ok2);
    t2 = cyc;
    checks++;
    if (!ok2 || (t2 - t1) != 15) begin
      failures++;
      $display("FAIL b2b_spacing got %0d cycles want 15", t2 - t1);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL b2b_second got empty scoreboard want one entry");
    end else begin
      exp = sb.pop_front();
      if (observed() !== exp) begin
        failures++;
        $display("FAIL b2b_second got %h want %h", observed(), exp);
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    logic [16:0] exp;
    int vals[2] = '{12345, 42};
    for (int k = 0; k < 2; k++) begin
      issue(vals[k]);
      checks++;
      if (bus.overflow !== (vals[k] > 9999)) begin
        failures++;
        $display("FAIL overflow_at_start value=%0d got %b want %b", vals[k], bus.overflow, vals[k] > 9999);
      end
      wait_done(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL saturation_timeout value=%0d got no done want done", vals[k]);
        sb.delete();
      end else begin
        exp = sb.pop_front();
        if (observed() !== exp) begin
          failures++;
          $display("FAIL saturation value=%0d got %h want %h", vals[k], observed(), exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit extra = 1'b0;
    logic [16:0] exp;
    issue(5678);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || observed() !== 17'd0) begin
      failures++;
      $display("FAIL reset_mid_state got busy,done=%b%b digits=%h want 00 and 0", bus.busy, bus.done, observed());
    end
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL reset_mid_no_done got done pulse want none");
    end
    issue(1234);
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_mid_restart_timeout got no done want done");
      sb.delete();
    end else begin
      exp = sb.pop_front();
      if (observed() !== exp) begin
        failures++;
        $display("FAIL reset_mid_restart got %h want %h", observed(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_units_tens();
    test_boundaries();
    test_timing();
    test_mid_start();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
- Sequential binary-to-BCD converter for the 4-digit display path.
- Converts a 14-bit unsigned binary value in the range 0..9999 into four BCD digits: thousands, hundreds, tens and ones.
- Uses an iterative double-dabble algorithm (shift-and-add-3) with a start/done handshake.
- Sits between the numeric source and the 7-segment/TM1637 digit encoder.

Parameters:
- IN_W, 14, binary input width; fixed by the 0..9999 range. Other values are unsupported.
- MAX_VAL, 9999, largest representable value. Larger inputs saturate to this value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion of number. Honoured only when idle.
- number  input  14  unsigned binary value to convert.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when the digit outputs update.
- overflow  output  1  high when the last accepted number exceeded MAX_VAL.
- thousands  output  4  BCD digit 10^3.
- hundreds  output  4  BCD digit 10^2.
- tens  output  4  BCD digit 10^1.
- ones  output  4  BCD digit 10^0.

Behaviour:
- Reset: when rst is high at a rising edge, return to IDLE and clear busy, done, overflow and all four digits to 0. Reset in the middle of a conversion aborts it and produces no done pulse.
- States: IDLE and SHIFT.
- IDLE, start=1 at edge E0:
  - Capture the value to convert. If number > 9999, capture 9999 and set overflow=1; otherwise capture number and set overflow=0.
  - Clear the 16-bit BCD scratch register.
  - Load the iteration counter with 14.
  - Go to SHIFT; busy=1 from E0.
- SHIFT, each edge:
  - For each of the 4 scratch nibbles: if the nibble >= 5, add 3 to it.
  - Then shift {scratch, binary} left by 1 as one combined register.
  - Decrement the counter.
- Completion: the 14th shift occurs at edge E14. At E14:
  - Copy the scratch nibbles to thousands, hundreds, tens and ones.
  - Set done=1 for exactly one cycle.
  - Set busy=0 and return to IDLE.
- Latency: 14 clock edges from the start-sampling edge to valid digits.
- start while busy is ignored; the in-flight conversion is unaffected.
- start in the cycle where done=1 is accepted (FSM is already IDLE), giving back-to-back conversions every 15 cycles.
- Digit outputs and overflow hold their values between conversions. overflow updates at E0; digits update only at done.
- Every output digit is always in the range 0..9.
- number is sampled only at E0; changes during SHIFT have no effect.

Decomposition:
- Shared package bcd_pkg holds:
  - IN_W=14, DIGIT_W=4, NUM_DIGITS=4, MAX_VAL=9999.
  - A state enum {IDLE, SHIFT}.
- One sub-module, bcd_digit_adj: 4-bit combinational add-3-if->=5. Instantiate it four times in the shift datapath.

Test Plan:
- Units/tens boundary: convert 5..14 in sequence -> digits 0,0,0,5 up to 0,0,1,4. In particular 9 -> 0,0,0,9 and 10 -> 0,0,1,0; overflow=0 throughout.
- Hundreds/thousands boundaries:
  - 95..104 -> 99 gives 0,0,9,9 and 100 gives 0,1,0,0.
  - 995..1004 -> 999 gives 0,9,9,9 and 1000 gives 1,0,0,0.
  - 9995..9999 -> 9999 gives 9,9,9,9.
  - 0 -> 0,0,0,0.
- Timing/handshake:
  - Start pulse at edge E0 -> busy high E0..E14, done high exactly one cycle after E14, digits unchanged before E14.
  - A second start pulsed mid-conversion is ignored.
  - Start asserted during done -> a new conversion begins, with the next done 15 cycles after the first.
- Saturation:
  - number=12345 -> digits 9,9,9,9 with overflow=1.
  - Next conversion of 42 -> 0,0,4,2 with overflow=0.
- Reset mid-conversion: assert rst at the 7th SHIFT edge -> no done, all digits 0, busy 0. A subsequent start of 1234 -> 1,2,3,4.
